// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types, sizes and the output saturation helper for the FIR MAC sequencer.
package fir_pkg;

  localparam int NTaps     = 13;
  localparam int DataWidth = 8;
  localparam int AccWidth  = 2 * DataWidth + $clog2(NTaps);
  localparam int TapWidth  = $clog2(NTaps);

  typedef logic signed [DataWidth-1:0]   sample_t;
  typedef logic signed [DataWidth-1:0]   coef_t;
  typedef logic signed [2*DataWidth-1:0] prod_t;
  typedef logic signed [AccWidth-1:0]    acc_t;
  typedef logic [TapWidth-1:0]           tap_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam tap_t LastTap  = tap_t'(NTaps - 1);
  localparam tap_t TapCount = tap_t'(NTaps);

  localparam acc_t SatMax = acc_t'((1 << (DataWidth - 1)) - 1);
  localparam acc_t SatMin = acc_t'(-(1 << (DataWidth - 1)));

  // Rescale a Q1.(DataWidth-1) product sum back to sample format; the shift floors.
  function automatic sample_t saturate(acc_t acc);
    acc_t shifted;
    shifted = acc >>> (DataWidth - 1);
    if (shifted > SatMax) return sample_t'(SatMax);
    if (shifted < SatMin) return sample_t'(SatMin);
    return sample_t'(shifted);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-load and result signals between the FIR sequencer and its neighbours.
interface fir_mac_sequencer_if import fir_pkg::*; ();

  logic    sampleValid;
  sample_t sampleIn;
  logic    ready;
  logic    coefWrEn;
  tap_t    coefWrAddr;
  coef_t   coefWrData;
  logic    coefCommit;
  logic    resultValid;
  sample_t result;
  logic    overrun;

  modport master (
    output sampleValid, sampleIn, coefWrEn, coefWrAddr, coefWrData, coefCommit,
    input  ready, resultValid, result, overrun
  );

  modport slave (
    input  sampleValid, sampleIn, coefWrEn, coefWrAddr, coefWrData, coefCommit,
    output ready, resultValid, result, overrun
  );

endinterface

// File: rtl/fir_mac_sequencer_mac.sv
// Shared MAC datapath: combinational signed multiply into a registered accumulator.
module fir_mac
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clear_i,
  input  logic    en_i,
  input  coef_t   coef_i,
  input  sample_t sample_i,
  output acc_t    acc_o
);

  prod_t product;
  acc_t  acc_q, acc_d;

  // Sign-extending casts keep the full-precision product.
  assign product = prod_t'(coef_i) * prod_t'(sample_i);

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = acc_q + acc_t'(product);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer: circular delay line, double-buffered coefficients and serial MAC scheduling.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fir_mac_sequencer_if.slave   bus
);

  state_e  state_q, state_d;
  sample_t delay_q  [NTaps];
  sample_t delay_d  [NTaps];
  coef_t   shadow_q [NTaps];
  coef_t   shadow_d [NTaps];
  coef_t   active_q [NTaps];
  coef_t   active_d [NTaps];
  tap_t    head_q, head_d;
  tap_t    tap_q, tap_d;
  logic    pending_q, pending_d;
  logic    overrun_q, overrun_d;
  logic    rvalid_q, rvalid_d;
  sample_t result_q, result_d;

  logic accept, swap;
  tap_t rd_idx;
  acc_t acc;

  // Tap k reads the sample written k acceptances ago; modular wrap keeps the 4-bit sum exact.
  assign rd_idx = (head_q >= tap_q) ? tap_t'(head_q - tap_q)
                                    : tap_t'(head_q + TapCount - tap_q);

  // NOTE: every variable gets its default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    head_d    = head_q;
    tap_d     = tap_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    rvalid_d  = 1'b0;
    result_d  = result_q;

    accept = (state_q == IDLE) && bus.sampleValid;
    swap   = (state_q == IDLE) && (pending_q || bus.coefCommit);

    if (bus.coefWrEn && (bus.coefWrAddr <= LastTap)) shadow_d[bus.coefWrAddr] = bus.coefWrData;

    // The copy takes shadow_d so a same-edge write lands in the committed bank.
    if (swap) active_d = shadow_d;
    pending_d = swap ? 1'b0 : (pending_q || bus.coefCommit);

    if (bus.sampleValid && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          delay_d[head_q] = bus.sampleIn;
          tap_d           = '0;
          state_d         = MAC;
        end
      end
      MAC: begin
        if (tap_q == LastTap) state_d = OUT;
        else                  tap_d   = tap_q + tap_t'(1);
      end
      OUT: begin
        result_d = saturate(acc);
        rvalid_d = 1'b1;
        head_d   = (head_q == LastTap) ? '0 : head_q + tap_t'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the delay line and both coefficient banks are explicitly reset, since
  // stale taps or coefficients would leak into the first outputs after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      delay_q   <= '{default: '0};
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      head_q    <= '0;
      tap_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      head_q    <= head_d;
      tap_q     <= tap_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rvalid_q  <= rvalid_d;
      result_q  <= result_d;
    end
  end

  fir_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .en_i     (state_q == MAC),
    .coef_i   (active_q[tap_q]),
    .sample_i (delay_q[rd_idx]),
    .acc_o    (acc)
  );

  assign bus.ready       = (state_q == IDLE);
  assign bus.resultValid = rvalid_q;
  assign bus.result      = result_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Controller that schedules the shared multiply-accumulate datapath of the FIR engine. For each audio sample from the I2S2 receive path it writes a circular delay line, then runs NTaps serial MAC cycles against the active coefficient bank. It emits one saturated output sample for the I2S2 transmit path. It also owns the double-buffered coefficient store: the SPI loader writes the shadow bank, and a commit is applied only between samples.

Parameters:
NTaps, 13, number of filter taps (>=2)
DataWidth, 8, signed sample and coefficient width; coefficients are Q1.(DataWidth-1)
AccWidth, 2*DataWidth+$clog2(NTaps), signed accumulator width (20 at defaults)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sampleValid  in  1  one-cycle strobe, new input sample
sampleIn  in  DataWidth  signed input sample
ready  out  1  high when idle; a sample is accepted only when ready
coefWrEn  in  1  write strobe into shadow bank
coefWrAddr  in  $clog2(NTaps)  tap index for write
coefWrData  in  DataWidth  signed coefficient
coefCommit  in  1  request copy of shadow bank into active bank
resultValid  out  1  one-cycle strobe, result valid
result  out  DataWidth  signed saturated filter output
overrun  out  1  sticky, a sample arrived while busy

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset clears: delay line, both coefficient banks, write pointer, tap counter, accumulator, pendingSwap, result=0, resultValid=0, overrun=0. State goes to IDLE, so ready=1.
- Reset mid-computation aborts the computation. No resultValid is produced for the aborted sample.
- FSM states:
  - IDLE: ready=1. On sampleValid, write sampleIn at headPtr, clear acc, set tapIdx=0, go to MAC.
  - MAC: each cycle, acc += coefActive[tapIdx] * delay[(headPtr - tapIdx) mod NTaps]. The product is a signed full 2*DataWidth-bit value, sign-extended to AccWidth.
    - At tapIdx=NTaps-1, go to OUT. Otherwise increment tapIdx.
  - OUT: register result = sat(acc >>> (DataWidth-1)) and pulse resultValid for one cycle. Advance headPtr mod NTaps (wraps NTaps-1 to 0). Go to IDLE.
- Timing, with sampleValid accepted at edge E0:
  - MAC accumulates on edges E1..E_NTaps.
  - result and resultValid are registered at E_{NTaps+1}; resultValid is high for exactly one cycle.
  - ready is low for NTaps+1 cycles.
  - Maximum throughput is one sample per NTaps+2 cycles.
- The sample written at E0 is tap 0 of its own computation. Older samples occupy taps 1..NTaps-1.
- Saturation: the arithmetic shift floors. Clamp to [-2^(DataWidth-1), 2^(DataWidth-1)-1], i.e. [-128, 127] at defaults.
- sampleValid while not ready: the sample is dropped, overrun is set and held until reset, and the current computation is unaffected.
- Coefficient writes:
  - coefWrEn writes the shadow bank in any state.
  - coefWrAddr >= NTaps is ignored.
- coefCommit sets pendingSwap.
- Swap rule:
  - When state is IDLE and (pendingSwap or coefCommit), copy the whole shadow bank into the active bank and clear pendingSwap.
  - If a sample is accepted on the same edge, that sample uses the new coefficients.
  - The active bank never changes during MAC or OUT.
- A write and a commit on the same edge: the committed copy includes the new word (bypass required). The shadow bank is retained after a swap.

Decomposition:
- Package fir_pkg:
  - state enum (IDLE, MAC, OUT)
  - sample_t and coef_t (signed DataWidth)
  - acc_t (signed AccWidth)
  - saturate function
  - tap index width constant
- Sub-module fir_mac: combinational signed multiply plus registered accumulate with clear and enable. The sequencer owns the FSM, the pointers, the delay line and both coefficient banks.

Test Plan:
1. Impulse: coef[0]=127, others 0, commit. Feed 64, then 12 zeros. Required response: first result 63, then twelve results of 0.
2. Saturation: all coefs 127, 13 samples of 127. Acc=209677, so the 13th result is 127. Repeat with 13 samples of -128: acc=-211328, so the 13th result is -128.
3. Latency and ready: accept a sample at E0. resultValid must be high only in the cycle after E14. ready must be low for 14 cycles. A sampleValid at E15 is accepted.
4. Overrun: a second sampleValid at E5 is dropped, overrun rises and stays high, the first result is unchanged, and no extra resultValid appears.
5. Commit during MAC: load a new shadow bank and pulse coefCommit at E3. The current result uses the old coefficients and the next sample uses the new ones. Also check a write plus commit on the same edge in IDLE, with a sample on that same edge: that sample uses the new word.
6. Reset at E7: no resultValid, outputs 0, ready=1, delay line zeroed (verified by the impulse test giving 63 then 0s).
